// File: rtl/round_pkg.sv
// -----------------------------------------------------------------------------
// round_pkg
// Shared types, default parameter values and the BCD helper for the game round
// countdown controller (round_timer).
// -----------------------------------------------------------------------------
package round_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        PAUSE     = 3'd2,
        ROUND_END = 3'd3,
        DONE      = 3'd4
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int ROUND_SECONDS_DFLT = 30;
    localparam int NUM_ROUNDS_DFLT    = 5;
    localparam int WARN_SECONDS_DFLT  = 5;

    // Two-digit BCD of a value in 0..99, packed as {tens, ones}.
    function automatic logic [7:0] to_bcd(input int value);
        bcd_t t;
        bcd_t o;
        t = bcd_t'(value / 10);
        o = bcd_t'(value % 10);
        return {t, o};
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Two-flop synchronizer followed by a rising-edge detector. The pulse is one
// clk_i cycle wide. All flops clear on reset, so an input that is already high
// at reset release produces one edge pulse.
//
// Ports:
//   clk_i    in   system clock
//   rst_i    in   asynchronous active-high reset
//   d_i      in   asynchronous level input
//   pulse_o  out  one-cycle pulse on a synchronized rising edge
// -----------------------------------------------------------------------------
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic pulse_o
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign pulse_o = sync_q & ~hist_q;

endmodule

// File: rtl/round_timer.sv
// -----------------------------------------------------------------------------
// round_timer
// Game round countdown controller. Samples the divided round clock as data in
// the iclk domain (each rising edge = one time unit), counts a BCD time-left
// value down per round, sequences rounds and pause, and flags round end and
// game over.
//
// Parameters:
//   ROUND_SECONDS  time units per round (1..99)
//   NUM_ROUNDS     rounds per game (1..15)
//   WARN_SECONDS   low-time warning threshold (0..99)
//
// Ports:
//   iclk        in   system clock
//   reset       in   asynchronous active-high reset
//   round_tick  in   divided clock level; rising edge = one time unit
//   start       in   start/resume request level; rising edge acts
//   pause       in   pause toggle level; rising edge acts
//   tens        out  BCD tens digit of time left
//   ones        out  BCD ones digit of time left
//   round_num   out  current round, 1..NUM_ROUNDS
//   running     out  high in RUN
//   round_done  out  one-cycle pulse at the end of each round
//   game_over   out  high in DONE
//   warn        out  low-time warning blink
//
// Build option:
//   ROUND_TIMER_WARN_BLINK_EN  when defined, warn blinks in RUN/PAUSE while
//                              0 < time left <= WARN_SECONDS; otherwise warn
//                              is tied low.
//
// States:
//   IDLE      | counter held at ROUND_SECONDS, waiting for start
//   RUN       | counting down on tick pulses
//   PAUSE     | counter frozen, ticks dropped
//   ROUND_END | one cycle, round_done pulse, counter reads 00
//   DONE      | game over, counter holds 00 until start
// -----------------------------------------------------------------------------
module round_timer
    import round_pkg::*;
#(
    parameter int ROUND_SECONDS = ROUND_SECONDS_DFLT,
    parameter int NUM_ROUNDS    = NUM_ROUNDS_DFLT,
    parameter int WARN_SECONDS  = WARN_SECONDS_DFLT
) (
    input  logic       iclk,
    input  logic       reset,
    input  logic       round_tick,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [3:0] round_num,
    output logic       running,
    output logic       round_done,
    output logic       game_over,
    output logic       warn
);

    localparam logic [7:0] ROUND_BCD  = to_bcd(ROUND_SECONDS);
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    if (ROUND_SECONDS < 1 || ROUND_SECONDS > 99 ||
        NUM_ROUNDS < 1 || NUM_ROUNDS > 15 ||
        WARN_SECONDS < 0 || WARN_SECONDS > 99) begin : g_bad_param
        $error("round_timer: parameter out of legal range");
    end

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic tick_p;
    logic start_p;
    logic pause_p;

    sync_edge_detect u_sync_tick (
        .clk_i   (iclk),
        .rst_i   (reset),
        .d_i     (round_tick),
        .pulse_o (tick_p)
    );

    sync_edge_detect u_sync_start (
        .clk_i   (iclk),
        .rst_i   (reset),
        .d_i     (start),
        .pulse_o (start_p)
    );

    sync_edge_detect u_sync_pause (
        .clk_i   (iclk),
        .rst_i   (reset),
        .d_i     (pause),
        .pulse_o (pause_p)
    );

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    bcd_t       tens_q, tens_d;
    bcd_t       ones_q, ones_d;
    logic [3:0] round_q, round_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       over_q, over_d;

    always_ff @(posedge iclk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tens_q    <= ROUND_BCD[7:4];
            ones_q    <= ROUND_BCD[3:0];
            round_q   <= 4'd1;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            round_q   <= round_d;
            running_q <= running_d;
            done_q    <= done_d;
            over_q    <= over_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        round_d = round_q;

        unique case (state_q)
            IDLE: begin
                tens_d = ROUND_BCD[7:4];
                ones_d = ROUND_BCD[3:0];
                if (start_p) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                // Pause takes priority; a tick in the same cycle is lost.
                if (pause_p) begin
                    state_d = PAUSE;
                end else if (tick_p) begin
                    if (tens_q == 4'd0 && ones_q <= 4'd1) begin
                        // Last unit of the round; also clamps at 00.
                        tens_d  = 4'd0;
                        ones_d  = 4'd0;
                        state_d = ROUND_END;
                    end else if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end

            PAUSE: begin
                if (pause_p || start_p) begin
                    state_d = RUN;
                end
            end

            ROUND_END: begin
                tens_d = 4'd0;
                ones_d = 4'd0;
                if (round_q == LAST_ROUND) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                    tens_d  = ROUND_BCD[7:4];
                    ones_d  = ROUND_BCD[3:0];
                    state_d = IDLE;
                end
            end

            DONE: begin
                tens_d = 4'd0;
                ones_d = 4'd0;
                if (start_p) begin
                    round_d = 4'd1;
                    tens_d  = ROUND_BCD[7:4];
                    ones_d  = ROUND_BCD[3:0];
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                round_d = 4'd1;
                tens_d  = ROUND_BCD[7:4];
                ones_d  = ROUND_BCD[3:0];
            end
        endcase

        // Status outputs are registered copies of the next state.
        running_d = (state_d == RUN);
        done_d    = (state_d == ROUND_END);
        over_d    = (state_d == DONE);
    end

    assign tens       = tens_q;
    assign ones       = ones_q;
    assign round_num  = round_q;
    assign running    = running_q;
    assign round_done = done_q;
    assign game_over  = over_q;

    // ------------------------------------------------------------------
    // Low-time warning
    // ------------------------------------------------------------------
`ifdef ROUND_TIMER_WARN_BLINK_EN
    localparam logic [7:0] WARN_BCD = to_bcd(WARN_SECONDS);

    logic win_q, win_d;
    logic warn_q, warn_d;
    logic tick_acc;

    always_comb begin
        // Only a decrementing tick toggles the blink; a tick lost to pause does not.
        tick_acc = (state_q == RUN) && tick_p && !pause_p;
        // BCD ordering matches numeric ordering, so the window compare is direct.
        win_d    = (state_d == RUN || state_d == PAUSE) &&
                   ({tens_d, ones_d} != 8'h00) &&
                   ({tens_d, ones_d} <= WARN_BCD);
        warn_d   = 1'b0;
        if (win_d) begin
            if (!win_q) begin
                warn_d = 1'b1;
            end else if (tick_acc) begin
                warn_d = ~warn_q;
            end else begin
                warn_d = warn_q;
            end
        end
    end

    always_ff @(posedge iclk or posedge reset) begin
        if (reset) begin
            win_q  <= 1'b0;
            warn_q <= 1'b0;
        end else begin
            win_q  <= win_d;
            warn_q <= warn_d;
        end
    end

    assign warn = warn_q;
`else
    assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_round_timer.sv
// -----------------------------------------------------------------------------
// tb_round_timer
// Directed bench for round_timer with ROUND_SECONDS=12, NUM_ROUNDS=2,
// WARN_SECONDS=3. Inputs change on the falling edge and outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_round_timer;

    logic       iclk = 1'b0;
    logic       reset = 1'b1;
    logic       round_tick = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] round_num;
    logic       running;
    logic       round_done;
    logic       game_over;
    logic       warn;

    int errors  = 0;
    int checks  = 0;
    int rd_seen = 0;
    logic [7:0] rd_cnt = 8'hFF;

`ifdef ROUND_TIMER_WARN_BLINK_EN
    localparam logic WARN_EN = 1'b1;
`else
    localparam logic WARN_EN = 1'b0;
`endif

    always #10 iclk = ~iclk;

    round_timer #(
        .ROUND_SECONDS (12),
        .NUM_ROUNDS    (2),
        .WARN_SECONDS  (3)
    ) dut (
        .iclk       (iclk),
        .reset      (reset),
        .round_tick (round_tick),
        .start      (start),
        .pause      (pause),
        .tens       (tens),
        .ones       (ones),
        .round_num  (round_num),
        .running    (running),
        .round_done (round_done),
        .game_over  (game_over),
        .warn       (warn)
    );

    // Raise the selected inputs for 4 cycles, drop for 4; counts round_done
    // pulses and records the counter seen alongside them.
    task automatic pulse_in(input logic t, input logic s, input logic p);
        round_tick = t;
        start      = s;
        pause      = p;
        repeat (4) begin
            @(negedge iclk);
            if (round_done) begin rd_seen++; rd_cnt = {tens, ones}; end
        end
        round_tick = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        repeat (4) begin
            @(negedge iclk);
            if (round_done) begin rd_seen++; rd_cnt = {tens, ones}; end
        end
    endtask

    task automatic test_reset();
        round_tick = 1'b1;
        reset      = 1'b1;
        repeat (3) @(negedge iclk);
        reset = 1'b0;
        repeat (6) @(negedge iclk);
        checks++;
        if ({tens, ones} !== 8'h12) begin
            errors++; $display("FAIL reset_count: got %h expected 12", {tens, ones});
        end
        checks++;
        if (round_num !== 4'd1) begin
            errors++; $display("FAIL reset_round: got %0d expected 1", round_num);
        end
        checks++;
        if ({running, round_done, game_over, warn} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000", {running, round_done, game_over, warn});
        end
        round_tick = 1'b0;
        repeat (3) @(negedge iclk);
        pulse_in(1'b1, 1'b0, 1'b0);
        pulse_in(1'b1, 1'b0, 1'b1);
        checks++;
        if ({tens, ones, running} !== {8'h12, 1'b0}) begin
            errors++; $display("FAIL idle_ignores_tick: got %h run=%b expected 12 run=0", {tens, ones}, running);
        end
    endtask

    task automatic test_run_borrow();
        logic [7:0] exp_cnt [3];
        exp_cnt = '{8'h11, 8'h10, 8'h09};
        pulse_in(1'b0, 1'b1, 1'b0);
        checks++;
        if ({running, tens, ones} !== {1'b1, 8'h12}) begin
            errors++; $display("FAIL run_start: got run=%b %h expected run=1 12", running, {tens, ones});
        end
        for (int i = 0; i < 3; i++) begin
            pulse_in(1'b1, 1'b0, 1'b0);
            checks++;
            if ({tens, ones} !== exp_cnt[i]) begin
                errors++; $display("FAIL run_tick%0d: got %h expected %h", i, {tens, ones}, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_pause_tick_same();
        pulse_in(1'b1, 1'b0, 1'b1);
        checks++;
        if ({running, tens, ones} !== {1'b0, 8'h09}) begin
            errors++; $display("FAIL pause_wins: got run=%b %h expected run=0 09", running, {tens, ones});
        end
        pulse_in(1'b1, 1'b0, 1'b0);
        pulse_in(1'b1, 1'b0, 1'b0);
        checks++;
        if ({tens, ones} !== 8'h09) begin
            errors++; $display("FAIL pause_frozen: got %h expected 09", {tens, ones});
        end
        pulse_in(1'b0, 1'b1, 1'b0);
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL resume: got run=%b expected 1", running);
        end
        pulse_in(1'b1, 1'b0, 1'b0);
        checks++;
        if ({tens, ones} !== 8'h08) begin
            errors++; $display("FAIL resume_tick: got %h expected 08", {tens, ones});
        end
    endtask

    task automatic test_round_end();
        logic [7:0] exp_cnt [7];
        logic       exp_warn [7];
        int         rd0;
        exp_cnt  = '{8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        exp_warn = '{1'b0, 1'b0, 1'b0, 1'b0, WARN_EN, 1'b0, WARN_EN};
        for (int i = 0; i < 7; i++) begin
            pulse_in(1'b1, 1'b0, 1'b0);
            checks++;
            if ({tens, ones, warn} !== {exp_cnt[i], exp_warn[i]}) begin
                errors++; $display("FAIL down_%h: got %h warn=%b expected %h warn=%b", exp_cnt[i], {tens, ones}, warn, exp_cnt[i], exp_warn[i]);
            end
        end
        rd0    = rd_seen;
        rd_cnt = 8'hFF;
        pulse_in(1'b1, 1'b0, 1'b0);
        checks++;
        if (rd_seen - rd0 !== 1) begin
            errors++; $display("FAIL round1_done_pulses: got %0d expected 1", rd_seen - rd0);
        end
        checks++;
        if (rd_cnt !== 8'h00) begin
            errors++; $display("FAIL round1_done_count: got %h expected 00", rd_cnt);
        end
        checks++;
        if ({round_num, tens, ones, running, game_over, warn} !== {4'd2, 8'h12, 3'b000}) begin
            errors++; $display("FAIL round1_after: got r=%0d %h run=%b go=%b warn=%b expected r=2 12 run=0 go=0 warn=0",
                               round_num, {tens, ones}, running, game_over, warn);
        end
    endtask

    task automatic test_game_over();
        int rd0;
        pulse_in(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) pulse_in(1'b1, 1'b0, 1'b0);
        checks++;
        if ({tens, ones, running} !== {8'h01, 1'b1}) begin
            errors++; $display("FAIL round2_at_01: got %h run=%b expected 01 run=1", {tens, ones}, running);
        end
        rd0    = rd_seen;
        rd_cnt = 8'hFF;
        pulse_in(1'b1, 1'b0, 1'b0);
        checks++;
        if (rd_seen - rd0 !== 1 || rd_cnt !== 8'h00) begin
            errors++; $display("FAIL round2_done: got pulses=%0d cnt=%h expected 1 and 00", rd_seen - rd0, rd_cnt);
        end
        checks++;
        if ({game_over, running, tens, ones, round_num} !== {2'b10, 8'h00, 4'd2}) begin
            errors++; $display("FAIL game_over: got go=%b run=%b %h r=%0d expected go=1 run=0 00 r=2",
                               game_over, running, {tens, ones}, round_num);
        end
        pulse_in(1'b1, 1'b0, 1'b1);
        checks++;
        if ({game_over, tens, ones} !== {1'b1, 8'h00}) begin
            errors++; $display("FAIL done_hold: got go=%b %h expected go=1 00", game_over, {tens, ones});
        end
        pulse_in(1'b0, 1'b1, 1'b0);
        checks++;
        if ({game_over, running, round_num, tens, ones} !== {2'b00, 4'd1, 8'h12}) begin
            errors++; $display("FAIL restart: got go=%b run=%b r=%0d %h expected go=0 run=0 r=1 12",
                               game_over, running, round_num, {tens, ones});
        end
    endtask

    task automatic test_reset_mid();
        int rd0;
        pulse_in(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) pulse_in(1'b1, 1'b0, 1'b0);
        checks++;
        if ({tens, ones} !== 8'h05) begin
            errors++; $display("FAIL mid_at_05: got %h expected 05", {tens, ones});
        end
        rd0 = rd_seen;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({tens, ones, round_num, running, round_done} !== {8'h12, 4'd1, 2'b00}) begin
            errors++; $display("FAIL mid_reset: got %h r=%0d run=%b rd=%b expected 12 r=1 run=0 rd=0",
                               {tens, ones}, round_num, running, round_done);
        end
        repeat (2) @(negedge iclk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge iclk);
            if (round_done) rd_seen++;
        end
        checks++;
        if (rd_seen !== rd0 || {tens, ones} !== 8'h12) begin
            errors++; $display("FAIL mid_after: got pulses=%0d %h expected 0 and 12", rd_seen - rd0, {tens, ones});
        end
    endtask

    initial begin
        test_reset();
        test_run_borrow();
        test_pause_tick_same();
        test_round_end();
        test_game_over();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
